tlc_actuated: RTL
=================

Name: tlc_actuated

Overview:
- Parametrised, sensor-actuated two-road traffic light controller. Successor to the fixed-sequence main/side controller.
- Adds per-phase durations in seconds from an internal prescaler, all-red clearance intervals, side-road gap-out and max-out, a latched side request, and emergency preemption that forces main-road green.
- Sits between the road sensors and the lamp drivers; one instance per junction.

Parameters:
- CLK_PER_SEC, 1000: clk cycles per one-second tick.
- TIMER_W, 8: width of the seconds counter.
- MAIN_MIN_GREEN, 10: minimum main green, in seconds.
- YELLOW_TIME, 3: yellow duration for both roads, in seconds.
- ALL_RED_TIME, 1: all-red clearance after each yellow, in seconds.
- SIDE_MIN_GREEN, 5: minimum side green, in seconds.
- SIDE_MAX_GREEN, 20: maximum side green, in seconds.

Ports:
- clk  in  1  system clock. One clock domain.
- rst_n  in  1  reset. Asynchronous assertion, active-low.
- sensor  in  1  side-road vehicle detect. Asynchronous level input.
- preempt  in  1  emergency request for main-road priority. Asynchronous level input.
- main_road_light  out  3  main lamps, one-hot {R,Y,G}: 100 red, 010 yellow, 001 green.
- side_road_light  out  3  side lamps, same encoding.
- state_o  out  3  current state code, for debug.
- second  out  TIMER_W  whole seconds elapsed in the current state.
- side_req  out  1  latched side-road request.

Behaviour:
- Reset values (rst_n=0): state MG, second=0, prescaler=0, side_req=0, main_road_light=001, side_road_light=100. Leaving reset needs no clk edge.
- sensor and preempt each pass through a 2-flop synchroniser (sensor_s, preempt_s). This adds 2 cycles of latency.
- Prescaler:
  - Clears to 0 on every state change.
  - Otherwise counts up to CLK_PER_SEC-1, then wraps to 0.
  - tick is high when prescaler = CLK_PER_SEC-1.
- second: clears on every state change; increments on tick; saturates at 2^TIMER_W-1.
- "Timed out after D" means: tick high and second = D-1. A state that runs to its duration lasts exactly D*CLK_PER_SEC cycles.
- side_req:
  - Set when sensor_s=1 and state is not SG.
  - Cleared on entry to SG.
  - Set has priority except in SG.
- States (code: lamps main/side):
  - MG (0): 001/100.
  - MY (1): 010/100.
  - AR1 (2): 100/100.
  - SG (3): 100/001.
  - SY (4): 100/010.
  - AR2 (5): 100/100.
  - Codes 6 and 7 go to MG on the next clk edge.
- Transitions are evaluated every cycle and take effect on the next clk edge:
  - MG -> MY: side_req=1, preempt_s=0, and second >= MAIN_MIN_GREEN-1 on a tick. If the request arrives after min green has elapsed, the exit happens on the first tick with side_req=1.
  - MY -> AR1: timed out after YELLOW_TIME.
  - AR1 -> SG: timed out after ALL_RED_TIME and preempt_s=0.
  - AR1 -> MG: timed out after ALL_RED_TIME and preempt_s=1.
  - SG -> SY, preempt: preempt_s=1. Takes effect on the next edge with no tick wait, and overrides the minimum green.
  - SG -> SY, gap-out: on a tick with second >= SIDE_MIN_GREEN-1 and sensor_s=0.
  - SG -> SY, max-out: timed out after SIDE_MAX_GREEN, regardless of sensor.
  - SY -> AR2: timed out after YELLOW_TIME.
  - AR2 -> MG: timed out after ALL_RED_TIME.
- Preempt while in MY or SY does not shorten yellow.
- The two roads are never both non-red.
- Lamps, state_o and second are a combinational decode of registers only, with no input-to-output path.
- Simultaneous events: preempt outranks side_req and max-out. Reset outranks everything.
- Elaboration check: the build fails unless:
  - every duration >= 1 and < 2^TIMER_W;
  - SIDE_MIN_GREEN <= SIDE_MAX_GREEN;
  - CLK_PER_SEC >= 1.

Decomposition:
- Package tlc_pkg holds:
  - the state typedef (3-bit enum MG, MY, AR1, SG, SY, AR2);
  - lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001.
- Sub-module tlc_tick_gen: prescaler with synchronous clear input and tick output, parameter CLK_PER_SEC.
- Synchronisers and FSM live in tlc_actuated.

Test Plan (CLK_PER_SEC=4, other parameters at default):
- Idle: release reset, sensor=0 and preempt=0 for 2000 cycles -> state MG throughout, lamps 001/100, side_req=0, second saturates at 255.
- Early request: 1-cycle sensor pulse at cycle 8 -> side_req=1 at cycle 11 (2 sync cycles + 1 register cycle) -> MY entered at cycle 40. Then:
  - MY for 12 cycles;
  - AR1 for 4 cycles;
  - SG for 20 cycles (gap-out);
  - SY for 12 cycles;
  - AR2 for 4 cycles;
  - then MG, with side_req=0.
- Max-out: sensor held high -> SG lasts 80 cycles, then SY and AR2. MG then holds exactly 40 cycles before MY, because side_req was re-set during SY.
- Preempt in SG: preempt rises at SG second=2 -> SY entered 3 cycles later. After SY (12) and AR2 (4), MG holds while preempt=1, even with sensor=1 and side_req=1. After preempt falls, MY follows on the next tick.
- Preempt in MY: preempt high throughout MY -> MY lasts its full 12 cycles, AR1 lasts 4 cycles, then MG. SG is never entered.
- Reset mid-SY: assert rst_n=0 at SY second=1 -> lamps immediately 001/100 and second=0 with no clk edge. Normal sequence resumes after release.

Source files
------------

// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - state encoding and lamp constants shared by the tlc_actuated slice
package tlc_pkg;

  // Codes 6 and 7 are unused; the FSM steers them back to MG.
  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } tlc_state_e;

  // One-hot lamp drive {R,Y,G}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/tlc_tick_gen.sv
// rtl/tlc_tick_gen.sv - clock prescaler producing a one-cycle tick per second
// Ports:
//   clk, rst_n : clock and async active-low reset
//   clr        : synchronous clear of the prescaler (state change)
//   tick       : high while the prescaler sits on its last count
module tlc_tick_gen #(
  parameter int CLK_PER_SEC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded from the register only, so tick never depends on clr.
  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/tlc_actuated.sv
// rtl/tlc_actuated.sv - sensor-actuated two-road traffic light controller with preemption
// Ports:
//   clk, rst_n       : clock and async active-low reset
//   sensor           : side-road vehicle detect (async level)
//   preempt          : emergency request for main-road green (async level)
//   main_road_light  : main lamps {R,Y,G}
//   side_road_light  : side lamps {R,Y,G}
//   state_o          : current state code
//   second           : whole seconds spent in the current state
//   side_req         : latched side-road request
module tlc_actuated
  import tlc_pkg::*;
#(
  parameter int CLK_PER_SEC    = 1000,
  parameter int TIMER_W        = 8,
  parameter int MAIN_MIN_GREEN = 10,
  parameter int YELLOW_TIME    = 3,
  parameter int ALL_RED_TIME   = 1,
  parameter int SIDE_MIN_GREEN = 5,
  parameter int SIDE_MAX_GREEN = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sensor,
  input  logic               preempt,
  output logic [2:0]         main_road_light,
  output logic [2:0]         side_road_light,
  output logic [2:0]         state_o,
  output logic [TIMER_W-1:0] second,
  output logic               side_req
);

  localparam int DUR_LIMIT = 2 ** TIMER_W;

  if (CLK_PER_SEC < 1 ||
      MAIN_MIN_GREEN < 1 || MAIN_MIN_GREEN >= DUR_LIMIT ||
      YELLOW_TIME    < 1 || YELLOW_TIME    >= DUR_LIMIT ||
      ALL_RED_TIME   < 1 || ALL_RED_TIME   >= DUR_LIMIT ||
      SIDE_MIN_GREEN < 1 || SIDE_MIN_GREEN >= DUR_LIMIT ||
      SIDE_MAX_GREEN < 1 || SIDE_MAX_GREEN >= DUR_LIMIT ||
      SIDE_MIN_GREEN > SIDE_MAX_GREEN) begin : g_param_err
    $error("tlc_actuated: illegal parameter set");
  end

  // "Last second" values: a duration D expires on the tick where second = D-1.
  localparam logic [TIMER_W-1:0] MAIN_MIN_LAST = TIMER_W'(MAIN_MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] YEL_LAST      = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] AR_LAST       = TIMER_W'(ALL_RED_TIME - 1);
  localparam logic [TIMER_W-1:0] SIDE_MIN_LAST = TIMER_W'(SIDE_MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] SIDE_MAX_LAST = TIMER_W'(SIDE_MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] SEC_SAT       = '1;

  tlc_state_e         state_q, state_d;
  logic [TIMER_W-1:0] second_q, second_d;
  logic               side_req_q, side_req_d;
  logic               sensor_m_q, sensor_m_d, sensor_s_q, sensor_s_d;
  logic               preempt_m_q, preempt_m_d, preempt_s_q, preempt_s_d;
  logic               state_chg;
  logic               tick;

  tlc_tick_gen #(
    .CLK_PER_SEC (CLK_PER_SEC)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_chg),
    .tick  (tick)
  );

  // Next-state; preempt in SG is checked first so it beats gap-out and max-out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MG:  if (tick && side_req_q && !preempt_s_q && (second_q >= MAIN_MIN_LAST)) state_d = MY;
      MY:  if (tick && (second_q == YEL_LAST)) state_d = AR1;
      AR1: if (tick && (second_q == AR_LAST)) state_d = preempt_s_q ? MG : SG;
      SG: begin
        if (preempt_s_q) begin
          state_d = SY;
        end else if (tick && ((second_q == SIDE_MAX_LAST) ||
                              ((second_q >= SIDE_MIN_LAST) && !sensor_s_q))) begin
          state_d = SY;
        end
      end
      SY:  if (tick && (second_q == YEL_LAST)) state_d = AR2;
      AR2: if (tick && (second_q == AR_LAST)) state_d = MG;
      default: state_d = MG;
    endcase
  end

  assign state_chg = (state_d != state_q);

  always_comb begin
    sensor_m_d  = sensor;
    sensor_s_d  = sensor_m_q;
    preempt_m_d = preempt;
    preempt_s_d = preempt_m_q;

    second_d = second_q;
    if (state_chg) begin
      second_d = '0;
    end else if (tick && (second_q != SEC_SAT)) begin
      second_d = second_q + TIMER_W'(1);
    end

    // Entering SG consumes the request even if the sensor is still high;
    // otherwise a detect latches it in any state but SG.
    side_req_d = side_req_q;
    if ((state_d == SG) && (state_q != SG)) begin
      side_req_d = 1'b0;
    end else if (sensor_s_q && (state_q != SG)) begin
      side_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MG;
      second_q    <= '0;
      side_req_q  <= 1'b0;
      sensor_m_q  <= 1'b0;
      sensor_s_q  <= 1'b0;
      preempt_m_q <= 1'b0;
      preempt_s_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      second_q    <= second_d;
      side_req_q  <= side_req_d;
      sensor_m_q  <= sensor_m_d;
      sensor_s_q  <= sensor_s_d;
      preempt_m_q <= preempt_m_d;
      preempt_s_q <= preempt_s_d;
    end
  end

  // Lamp decode from the state register only; unknown codes show all-red.
  always_comb begin
    main_road_light = LAMP_RED;
    side_road_light = LAMP_RED;
    case (state_q)
      MG:      main_road_light = LAMP_GRN;
      MY:      main_road_light = LAMP_YEL;
      SG:      side_road_light = LAMP_GRN;
      SY:      side_road_light = LAMP_YEL;
      default: ;
    endcase
  end

  assign state_o  = state_q;
  assign second   = second_q;
  assign side_req = side_req_q;

endmodule
